// File: rtl/wino_input_trans.sv
// wino_input_trans: Winograd F(2x2,3x3) input transform V = Bt*d*B over a
// sliding 4-column window with horizontal stride 2, one registered tile per handshake.
// Define WINO_BYPASS_EN to add the bypass_op port and a raw-pixel output path.
module wino_input_trans #(
   parameter int PIX_W = 8,
   parameter int OUT_W = PIX_W + 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_first,
   input  logic [4*PIX_W-1:0]  in_col,
`ifdef WINO_BYPASS_EN
   input  logic                bypass_op,
`endif
   output logic                out_valid,
   input  logic                out_ready,
   output logic [16*OUT_W-1:0] out_tile
);
   localparam int T_W = PIX_W + 1;

   typedef enum logic {FILL, STEADY} state_t;

   state_t                  state, state_nx;
   logic [2:0]              cnt, cnt_nx;
   logic                    acc, restart, slide, load;
   logic signed [PIX_W-1:0] px [4];
   logic signed [T_W-1:0]   d [4];
   logic signed [T_W-1:0]   t [4];
   logic signed [T_W-1:0]   w [4][4];
   logic [16*OUT_W-1:0]     v, tile_nx;

   // A column only enters when the output slot is free or draining this cycle.
   assign in_ready = !out_valid || out_ready;
   assign acc      = in_valid && in_ready;

   for (genvar r = 0; r < 4; r++) begin : g_pix
      assign px[r] = in_col[PIX_W*r +: PIX_W];
      assign d[r]  = T_W'(px[r]);
   end

   // Column transform: Bt applied down the incoming column.
   assign t[0] = d[0] - d[2];
   assign t[1] = d[1] + d[2];
   assign t[2] = d[2] - d[1];
   assign t[3] = d[1] - d[3];

   // Next-state logic: restart a strip, slide by two, or append a column.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      restart  = 1'b0;
      slide    = 1'b0;
      load     = 1'b0;
      if (acc) begin
         if (in_first || cnt == 3'd0) begin
            restart  = 1'b1;
            state_nx = FILL;
            cnt_nx   = 3'd1;
         end else if (state == STEADY) begin
            slide    = 1'b1;
            state_nx = FILL;
            cnt_nx   = 3'd3;
         end else begin
            cnt_nx = cnt + 3'd1;
            if (cnt == 3'd3) begin
               load     = 1'b1;
               state_nx = STEADY;
            end
         end
      end
   end

   // State and column-count register; both hold while no column is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Window of transformed columns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w <= '{default: '{default: '0}};
      end else if (acc) begin
         if (slide) begin
            w[0] <= w[2];
            w[1] <= w[3];
            w[2] <= t;
         end else begin
            w[restart ? 2'd0 : cnt[1:0]] <= t;
         end
      end
   end

   // Row transform: B applied across w[0..2] and the completing column.
   for (genvar i = 0; i < 4; i++) begin : g_row
      logic signed [OUT_W-1:0] c0, c1, c2, c3;
      assign c0 = OUT_W'(w[0][i]);
      assign c1 = OUT_W'(w[1][i]);
      assign c2 = OUT_W'(w[2][i]);
      assign c3 = OUT_W'(t[i]);
      assign v[OUT_W*(4*i+0) +: OUT_W] = c0 - c2;
      assign v[OUT_W*(4*i+1) +: OUT_W] = c1 + c2;
      assign v[OUT_W*(4*i+2) +: OUT_W] = c2 - c1;
      assign v[OUT_W*(4*i+3) +: OUT_W] = c1 - c3;
   end

`ifdef WINO_BYPASS_EN
   logic signed [PIX_W-1:0] p [4][4];
   logic [16*OUT_W-1:0]     raw;

   // Raw-pixel window, updated in lockstep with the transformed window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p <= '{default: '{default: '0}};
      end else if (acc) begin
         if (slide) begin
            p[0] <= p[2];
            p[1] <= p[3];
            p[2] <= px;
         end else begin
            p[restart ? 2'd0 : cnt[1:0]] <= px;
         end
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_raw
      for (genvar j = 0; j < 3; j++) begin : g_col
         assign raw[OUT_W*(4*i+j) +: OUT_W] = OUT_W'(p[j][i]);
      end
      assign raw[OUT_W*(4*i+3) +: OUT_W] = OUT_W'(px[i]);
   end

   assign tile_nx = bypass_op ? raw : v;
`else
   assign tile_nx = v;
`endif

   // Output slot: load on the completing column, otherwise drain on consume.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_tile  <= '0;
      end else begin
         if (load) out_tile <= tile_nx;
         out_valid <= load || (out_valid && !out_ready);
      end
   end
endmodule

// File: tb/tb_wino_input_trans.sv
// tb_wino_input_trans: randomized self-checking bench for wino_input_trans
// against a matrix-level Bt*d*B reference model of each strip.
`timescale 1ns/1ps
module tb_wino_input_trans;
   localparam int PIX_W = 8;
   localparam int OUT_W = 10;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_first = 1'b0;
   logic                out_ready = 1'b1;
   logic [4*PIX_W-1:0]  in_col = '0;
   logic                in_ready, out_valid;
   logic [16*OUT_W-1:0] out_tile;
`ifdef WINO_BYPASS_EN
   logic                bypass_op = 1'b0;
`endif

   int checks = 0;
   int failures = 0;

   int cols [4][4];
   int k = -1;
   logic [16*OUT_W-1:0] exp_q [$];
   logic [16*OUT_W-1:0] got_q [$];
   bit obs_acc, obs_valid, obs_ready;
   logic [16*OUT_W-1:0] obs_tile;

   wino_input_trans #(.PIX_W(PIX_W), .OUT_W(OUT_W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_first(in_first),
      .in_col(in_col),
`ifdef WINO_BYPASS_EN
      .bypass_op(bypass_op),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_tile(out_tile)
   );

   always #5 clk = ~clk;

   function automatic logic [16*OUT_W-1:0] ref_tile(input bit byp);
      int bt [4][4] = '{'{1, 0, -1, 0}, '{0, 1, 1, 0}, '{0, -1, 1, 0}, '{0, 1, 0, -1}};
      logic [16*OUT_W-1:0] res = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            int acc_v;
            acc_v = 0;
            if (byp) acc_v = cols[j][i];
            else
               for (int a = 0; a < 4; a++)
                  for (int b = 0; b < 4; b++)
                     acc_v += bt[i][a] * cols[b][a] * bt[j][b];
            res[OUT_W*(4*i+j) +: OUT_W] = OUT_W'(acc_v);
         end
      return res;
   endfunction

   function automatic void model_accept(input logic [31:0] col, input bit first, input bit byp);
      if (first || k < 0) k = 0;
      else k++;
      for (int c = 0; c < 3; c++) cols[c] = cols[c+1];
      for (int r = 0; r < 4; r++) cols[3][r] = $signed(col[8*r +: 8]);
      if (k >= 3 && k % 2 == 1) exp_q.push_back(ref_tile(byp));
   endfunction

   function automatic logic [31:0] mk(input int p0, input int p1, input int p2, input int p3);
      logic [31:0] c;
      c[7:0] = 8'(p0);
      c[15:8] = 8'(p1);
      c[23:16] = 8'(p2);
      c[31:24] = 8'(p3);
      return c;
   endfunction

   task automatic cycle(input bit v, input logic [31:0] col, input bit first, input bit ordy, input bit byp);
      @(negedge clk);
      in_valid = v;
      in_col = col;
      in_first = first;
      out_ready = ordy;
`ifdef WINO_BYPASS_EN
      bypass_op = byp;
`endif
      #1;
      obs_valid = out_valid;
      obs_ready = in_ready;
      obs_tile = out_tile;
      if (out_valid && out_ready) got_q.push_back(out_tile);
      obs_acc = v && in_ready;
      if (obs_acc) model_accept(col, first, byp);
      @(posedge clk);
   endtask

   task automatic send(input logic [31:0] col, input bit first, input bit byp);
      int n = 0;
      do begin
         cycle(1'b1, col, first, 1'b1, byp);
         n++;
      end while (!obs_acc && n < 50);
      if (!obs_acc) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_ready=%b required 1", obs_ready);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      k = -1;
      got_q.delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", out_valid); end
      checks++;
      if (out_tile !== '0) begin failures++; $display("FAIL reset_tile: got %h required 0", out_tile); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b required 1", in_ready); end
   endtask

   task automatic test_ones();
      logic [16*OUT_W-1:0] e = '0;
      e[OUT_W*5 +: OUT_W] = 10'd4;
      do_reset();
      for (int c = 0; c < 4; c++) send(32'h01010101, c == 0, 1'b0);
      idle(1);
      checks++;
      if (obs_valid !== 1'b1) begin failures++; $display("FAIL ones_latency: out_valid %b required 1", obs_valid); end
      checks++;
      if (obs_tile !== e) begin failures++; $display("FAIL ones_tile: got %h required %h", obs_tile, e); end
      idle(1);
      checks++;
      if (obs_valid !== 1'b0) begin failures++; $display("FAIL ones_pulse: out_valid %b required 0", obs_valid); end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_strip();
      do_reset();
      for (int c = 0; c < 8; c++) send(mk(4*c, 1+4*c, 2+4*c, 3+4*c), c == 0, 1'b0);
      idle(2);
      checks++;
      if (got_q.size() !== 3) begin failures++; $display("FAIL strip_count: got %0d tiles required 3", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         logic [16*OUT_W-1:0] g, x;
         g = got_q.pop_front();
         x = exp_q.pop_front();
         checks++;
         if (g !== x) begin failures++; $display("FAIL strip_tile: got %h required %h", g, x); end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_stall();
      logic [31:0] c [6];
      do_reset();
      for (int i = 0; i < 6; i++) c[i] = $urandom;
      for (int i = 0; i < 4; i++) send(c[i], i == 0, 1'b0);
      for (int s = 0; s < 5; s++) begin
         cycle(1'b1, c[4], 1'b0, 1'b0, 1'b0);
         checks++;
         if (obs_ready !== 1'b0) begin failures++; $display("FAIL stall_ready: got %b required 0", obs_ready); end
         checks++;
         if (exp_q.size() == 0 || obs_tile !== exp_q[0])
            begin failures++; $display("FAIL stall_hold: got %h required held first tile", obs_tile); end
      end
      send(c[4], 1'b0, 1'b0);
      send(c[5], 1'b0, 1'b0);
      idle(2);
      checks++;
      if (got_q.size() !== 2) begin failures++; $display("FAIL stall_count: got %0d tiles required 2", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         logic [16*OUT_W-1:0] g, x;
         g = got_q.pop_front();
         x = exp_q.pop_front();
         checks++;
         if (g !== x) begin failures++; $display("FAIL stall_tile: got %h required %h", g, x); end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_extremes();
      do_reset();
      for (int c = 0; c < 6; c++)
         send(mk(c % 2 ? 127 : -128, c % 2 ? -128 : 127, c % 2 ? 127 : -128, c % 2 ? -128 : 127), c == 0, 1'b0);
      for (int c = 0; c < 4; c++) send(mk(-128, -128, -128, -128), c == 0, 1'b0);
      idle(2);
      checks++;
      if (got_q.size() !== 3) begin failures++; $display("FAIL ext_count: got %0d tiles required 3", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         logic [16*OUT_W-1:0] g, x;
         g = got_q.pop_front();
         x = exp_q.pop_front();
         checks++;
         if (g !== x) begin failures++; $display("FAIL ext_tile: got %h required %h", g, x); end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_restart();
      do_reset();
      send($urandom, 1'b1, 1'b0);
      send($urandom, 1'b0, 1'b0);
      send($urandom, 1'b1, 1'b0);
      send($urandom, 1'b0, 1'b0);
      send($urandom, 1'b0, 1'b0);
      idle(1);
      checks++;
      if (got_q.size() !== 0) begin failures++; $display("FAIL restart_early: got %0d tiles required 0", got_q.size()); end
      send($urandom, 1'b0, 1'b0);
      idle(2);
      checks++;
      if (got_q.size() !== 1) begin failures++; $display("FAIL restart_count: got %0d tiles required 1", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         logic [16*OUT_W-1:0] g, x;
         g = got_q.pop_front();
         x = exp_q.pop_front();
         checks++;
         if (g !== x) begin failures++; $display("FAIL restart_tile: got %h required %h", g, x); end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, i == 0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b required 0", out_valid); end
      checks++;
      if (out_tile !== '0) begin failures++; $display("FAIL midrst_tile: got %h required 0", out_tile); end
      k = -1;
      got_q.delete();
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) send($urandom, 1'b0, 1'b0);
      idle(2);
      checks++;
      if (got_q.size() !== 1) begin failures++; $display("FAIL midrst_count: got %0d tiles required 1", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         logic [16*OUT_W-1:0] g, x;
         g = got_q.pop_front();
         x = exp_q.pop_front();
         checks++;
         if (g !== x) begin failures++; $display("FAIL midrst_tile2: got %h required %h", g, x); end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 600; n++)
         cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 1'b0);
      idle(3);
      checks++;
      if (got_q.size() !== exp_q.size())
         begin failures++; $display("FAIL rand_count: got %0d tiles required %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         logic [16*OUT_W-1:0] g, x;
         g = got_q.pop_front();
         x = exp_q.pop_front();
         checks++;
         if (g !== x) begin failures++; $display("FAIL rand_tile: got %h required %h", g, x); end
      end
      got_q.delete();
      exp_q.delete();
   endtask

`ifdef WINO_BYPASS_EN
   task automatic test_bypass();
      logic [16*OUT_W-1:0] e;
      do_reset();
      for (int c = 0; c < 4; c++) send(mk(4*c-8, 1+4*c-8, 2+4*c-8, 3+4*c-8), c == 0, 1'b1);
      idle(1);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) e[OUT_W*(4*i+j) +: OUT_W] = OUT_W'(i + 4*j - 8);
      checks++;
      if (obs_tile !== e) begin failures++; $display("FAIL bypass_tile: got %h required %h", obs_tile, e); end
      got_q.delete();
      exp_q.delete();
   endtask
`endif

   initial begin
      test_reset();
      test_ones();
      test_strip();
      test_stall();
      test_extremes();
      test_restart();
      test_reset_mid();
      test_random();
`ifdef WINO_BYPASS_EN
      test_bypass();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wino_input_trans.md
# wino_input_trans

- Winograd F(2x2,3x3) input-transform stage at the front of the convolution datapath.
- Accepts a stream of 4-pixel vertical strips (one column per transfer) and keeps a sliding 4-column window with horizontal stride 2.
- Emits the 16-element tile V = Bᵀ·d·B for every complete window, one registered tile per handshake, to the multiply/channel-accumulate array ahead of the output transform.
- It is the producer end of the Bᵀ·d·B / Aᵀ·M·A pair.

## Interface
Parameters:
- `PIX_W`, 8: signed input pixel width.
- `OUT_W`, `PIX_W+2`: signed transformed element width. Only the default is supported.

Ports:
- `clk` in, 1 bit: single clock, rising edge.
- `rst_n` in, 1 bit: reset, asynchronous, active-low.
- `in_valid` in, 1 bit: column valid.
- `in_ready` out, 1 bit: column accepted when `in_valid && in_ready`.
- `in_first` in, 1 bit: the accepted column starts a new strip and becomes window column 0.
- `in_col` in, `4*PIX_W` bits: rows 0..3 of one column; row r is at `[PIX_W*r +: PIX_W]`.
- `out_valid` out, 1 bit: tile valid.
- `out_ready` in, 1 bit: tile consumed when `out_valid && out_ready`.
- `out_tile` out, `16*OUT_W` bits: element (i,j) is at `[OUT_W*(4*i+j) +: OUT_W]`, row-major with (0,0) at the LSB.
- `bypass_op` in, 1 bit: present only with `WINO_BYPASS_EN`.

## Operation
Column transform, combinational on the accepted column (Bᵀ applied to d0..d3):
- t0 = d0−d2
- t1 = d1+d2
- t2 = d2−d1
- t3 = d1−d3
- Each t is sign-extended to `PIX_W+1` bits.

Window:
- 4-entry register array `w[0..3]` of transformed columns plus a column counter `cnt` (0..4).
- On accept with `in_first`=1: the column is stored as `w[0]` and `cnt`=1.
- Otherwise the column is stored at `w[cnt]` and `cnt` increments.

State machine:
- FILL (`cnt`<4): a tile is emitted when the 4th column is accepted, then go to STEADY.
- STEADY: on the next accept, shift the window left by 2 (`w[0]`←`w[2]`, `w[1]`←`w[3]`), store the column at `w[2]`, set `cnt`=3 and go to FILL. The next accepted column completes the following tile.
- `in_first` on any accept forces FILL with `cnt`=1, and no tile is emitted for that column.
- Net effect: tiles start at columns 0, 2, 4, …. A trailing odd column is dropped.

Row transform (B applied across window columns c0..c3 = `w[0..3]`), computed per element row:
- col0 = c0−c2
- col1 = c1+c2
- col2 = c2−c1
- col3 = c1−c3
- Results are sign-extended to `OUT_W`. No saturation is needed: |V| ≤ 4·2^(PIX_W−1).

Output and flow control:
- `out_tile` is a single output register, loaded when the completing column is accepted.
- `in_ready = !out_valid || out_ready`. Columns that do not complete a tile also wait on this, which keeps ordering trivial.
- `out_valid` rises on the load and falls on consume unless a new tile loads in the same cycle; in that case it stays 1 and `out_tile` is replaced.
- `out_tile` must hold stable while `out_valid && !out_ready`.

## Timing
- Reset (asynchronous assert, synchronous-safe release): `out_valid`=0, `out_tile`=0, `cnt`=0, `w[*]`=0, state FILL. `in_ready` reads 1 after reset.
- Latency: completing column accepted at edge N → `out_valid`=1 with its tile in the cycle after edge N.
- Throughput: one column per cycle with `out_ready` held at 1, giving one tile every 2 columns in steady state.
- Back-pressure: with `out_ready`=0 and `out_valid`=1, `in_ready`=0, and window, counter and state hold.
- A reset mid-strip discards the window and any pending tile. The next column must carry `in_first`.
- A column without `in_first` arriving while `cnt`=0 after reset is treated as `in_first`.

## Configuration
- `WINO_BYPASS_EN` defined:
  - Adds the `bypass_op` port, sampled with each completing column.
  - When `bypass_op`=1, `out_tile` carries the raw pixels d(i,j) sign-extended to `OUT_W` instead of V. This is the non-Winograd (1x1 kernel / pooling) path.
  - The window keeps raw pixels in parallel for this path.
  - Windowing, stride and handshakes are unchanged.
- `WINO_BYPASS_EN` not defined: no `bypass_op` port, no raw-pixel storage, and the transform is always applied.

## Test plan
- Reset then 4 columns, all pixels = 1, `out_ready`=1 → one tile one cycle after the 4th accept, equal to Bᵀ·d·B: V(1,1)=4, V(1,2)=V(2,1)=V(2,2)=0, V(0,0)=0; `out_valid` is a 1-cycle pulse.
- 8-column strip, d(r,c)=r+4c, continuous input → exactly 3 tiles, starting at columns 0, 2 and 4; the second tile equals a reference model of columns 2..5.
- Stall: hold `out_ready`=0 for 5 cycles after the first tile → `in_ready`=0, `out_tile` stable, no column lost; the second tile is correct after release.
- Extremes: all pixels = −128 in a checkerboard pattern with +127 → no overflow; V matches a reference model within the 10-bit signed range.
- `in_first` asserted on the 3rd column of a strip → no tile emitted; the next tile uses only columns from the new strip.
- With `WINO_BYPASS_EN` and `bypass_op`=1, input d(r,c)=r+4c−8 → `out_tile` element (i,j) = i+4j−8, sign-extended.
